// File: rtl/joy_db15_tx.sv
// DB15 joystick device-side transmitter: emulates a '165 PISO chain polled by
// JOY_LOAD/JOY_CLK, shifting out ~{joystick2, joystick1} LSB first on JOY_DATA.
module joy_db15_tx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic        link_active
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CW = 6;
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FRAME_LEN = CW'(32);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_prev;
  logic                   load_prev;
  logic [31:0]            sr;
  logic [CW-1:0]          bitcnt;
  logic [TW-1:0]          tmo;

  logic                   clk_s;
  logic                   load_s;
  logic                   clk_rise;
  logic                   load_fall;
  logic [31:0]            sr_nxt;
  logic [CW-1:0]          bitcnt_nxt;
  logic [TW-1:0]          tmo_nxt;
  logic                   done_nxt;
  logic                   link_nxt;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign load_s    = load_sync[SYNC_STAGES-1];
  assign clk_rise  = clk_s & ~clk_prev;
  assign load_fall = ~load_s & load_prev;
  assign JOY_DATA  = sr[0];

  // State register; idle-high lines reset to 1 so no spurious edge follows reset
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync    <= '1;
      load_sync   <= '1;
      clk_prev    <= 1'b1;
      load_prev   <= 1'b1;
      sr          <= '1;
      bitcnt      <= '0;
      tmo         <= '0;
      frame_done  <= 1'b0;
      link_active <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], JOY_CLK};
      load_sync   <= {load_sync[SYNC_STAGES-2:0], JOY_LOAD};
      clk_prev    <= clk_s;
      load_prev   <= load_s;
      sr          <= sr_nxt;
      bitcnt      <= bitcnt_nxt;
      tmo         <= tmo_nxt;
      frame_done  <= done_nxt;
      link_active <= link_nxt;
    end
  end

  // Next-state: transparent load beats shift; timeout tracks polling activity
  always_comb begin
    sr_nxt     = sr;
    bitcnt_nxt = bitcnt;
    tmo_nxt    = tmo;
    done_nxt   = 1'b0;
    link_nxt   = link_active;

    if (!load_s) begin
      sr_nxt     = ~{joystick2, joystick1};
      bitcnt_nxt = '0;
    end else if (clk_rise) begin
      sr_nxt = {1'b1, sr[31:1]};
      if (bitcnt != FRAME_LEN) begin
        bitcnt_nxt = bitcnt + CW'(1);
      end
      done_nxt = (bitcnt == FRAME_LEN - CW'(1));
    end

    if (load_fall) begin
      tmo_nxt  = '0;
      link_nxt = 1'b1;
    end else begin
      if (tmo != TMO_MAX) begin
        tmo_nxt = tmo + TW'(1);
      end
      // Drop on the cycle the counter lands on its limit
      if (tmo_nxt == TMO_MAX) begin
        link_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Self-checking bench for joy_db15_tx: table-driven frames, corner-case
// sequences and randomized frames checked against a frame-level model.
module tb_joy_db15_tx;

  logic        clk;
  logic        reset;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        JOY_DATA;
  logic        frame_done;
  logic        link_active;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int bad_done = 0;

  joy_db15_tx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .reset(reset),
    .joystick1(joystick1),
    .joystick2(joystick2),
    .JOY_CLK(JOY_CLK),
    .JOY_LOAD(JOY_LOAD),
    .JOY_DATA(JOY_DATA),
    .frame_done(frame_done),
    .link_active(link_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame_done pulses counted once each; data must read released at that time
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (JOY_DATA !== 1'b1) bad_done++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    bit          chg;
    logic [15:0] j1a;
    logic [15:0] j2a;
    int          nclk;
    logic        exp_first;
    int          exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reader-side view: sample i is what JOY_DATA shows before clock i; beyond 32 the chain is empty
  function automatic logic [63:0] model(input logic [15:0] j1, input logic [15:0] j2, input int n);
    logic [31:0] f;
    logic [63:0] m;
    f = ~{j2, j1};
    m = '0;
    for (int i = 0; i <= n; i++) m[i] = (i < 32) ? f[i] : 1'b1;
    return m;
  endfunction

  task automatic run_frame(input logic [15:0] j1, input logic [15:0] j2, input bit chg,
                           input logic [15:0] j1a, input logic [15:0] j2a, input int nclk,
                           output logic [63:0] got, output int dones);
    int start;
    @(negedge clk);
    joystick1 = j1;
    joystick2 = j2;
    JOY_LOAD  = 1'b0;
    start     = done_cnt;
    repeat (4) @(negedge clk);
    JOY_LOAD = 1'b1;
    repeat (4) @(negedge clk);
    if (chg) begin
      joystick1 = j1a;
      joystick2 = j2a;
    end
    got = '0;
    for (int i = 0; i < nclk; i++) begin
      got[i]  = JOY_DATA;
      JOY_CLK = 1'b1;
      repeat (4) @(negedge clk);
      JOY_CLK = 1'b0;
      repeat (4) @(negedge clk);
    end
    got[nclk] = JOY_DATA;
    repeat (2) @(negedge clk);
    dones = done_cnt - start;
  endtask

  task automatic tmo_run(input bit twice);
    @(negedge clk);
    chk("tmo_idle_before", 64'(link_active), 64'(0));
    JOY_LOAD = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 2) chk("tmo_not_yet", 64'(link_active), 64'(0));
      if (k == 3) chk("tmo_rise", 64'(link_active), 64'(1));
      if (k == 17) chk("tmo_still_high", 64'(link_active), 64'(1));
      if (!twice && k == 18) chk("tmo_fall_single", 64'(link_active), 64'(0));
      if (twice && k == 18) chk("tmo_extended", 64'(link_active), 64'(1));
      if (twice && k == 27) chk("tmo_extended_last", 64'(link_active), 64'(1));
      if (twice && k == 28) chk("tmo_fall_double", 64'(link_active), 64'(0));
      if (k == 4 || k == 14) JOY_LOAD = 1'b1;
      if (twice && k == 10) JOY_LOAD = 1'b0;
    end
  endtask

  initial begin
    vec_t        tbl[5];
    logic [63:0] got;
    int          dones;
    string       nm;

    tbl[0] = '{16'h0001, 16'h8000, 1'b0, 16'h0000, 16'h0000, 32, 1'b0, 1};
    tbl[1] = '{16'h0001, 16'h8000, 1'b1, 16'hFFFF, 16'h8000, 34, 1'b0, 1};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 31, 1'b1, 0};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 33, 1'b0, 1};
    tbl[4] = '{16'hA5A5, 16'h3C3C, 1'b0, 16'h0000, 16'h0000, 32, 1'b0, 1};

    reset     = 1'b1;
    JOY_LOAD  = 1'b0;
    JOY_CLK   = 1'b0;
    joystick1 = 16'h0001;
    joystick2 = 16'h0000;

    // Reset held with load low: outputs stay idle
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_data", 64'(JOY_DATA), 64'(1));
      chk("reset_done", 64'(frame_done), 64'(0));
      chk("reset_link", 64'(link_active), 64'(0));
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_reset_load", 64'(JOY_DATA), 64'(0));
    JOY_LOAD = 1'b1;
    repeat (4) @(negedge clk);

    foreach (tbl[t]) begin
      run_frame(tbl[t].j1, tbl[t].j2, tbl[t].chg, tbl[t].j1a, tbl[t].j2a, tbl[t].nclk, got, dones);
      nm = $sformatf("tbl%0d", t);
      chk({nm, "_first"}, 64'(got[0]), 64'(tbl[t].exp_first));
      chk({nm, "_bits"}, got, model(tbl[t].j1, tbl[t].j2, tbl[t].nclk));
      chk({nm, "_done"}, 64'(dones), 64'(tbl[t].exp_done));
    end

    // Clock edges during load are discarded
    @(negedge clk);
    joystick1 = 16'h0002;
    joystick2 = 16'h0000;
    JOY_LOAD  = 1'b0;
    repeat (5) begin
      JOY_CLK = 1'b1;
      repeat (4) @(negedge clk);
      JOY_CLK = 1'b0;
      repeat (4) @(negedge clk);
    end
    JOY_LOAD = 1'b1;
    repeat (4) @(negedge clk);
    chk("prio_bit0", 64'(JOY_DATA), 64'(1));
    JOY_CLK = 1'b1;
    repeat (4) @(negedge clk);
    JOY_CLK = 1'b0;
    repeat (4) @(negedge clk);
    chk("prio_bit1", 64'(JOY_DATA), 64'(0));

    // Reset after 12 shifts abandons the frame
    run_frame(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'h0000, 12, got, dones);
    chk("midrst_before", 64'(JOY_DATA), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_data", 64'(JOY_DATA), 64'(1));
    chk("midrst_link", 64'(link_active), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(16'h0001, 16'h8000, 1'b0, 16'h0000, 16'h0000, 32, got, dones);
    chk("midrst_refrm_bits", got, model(16'h0001, 16'h8000, 32));
    chk("midrst_refrm_done", 64'(dones), 64'(1));

    repeat (20) @(negedge clk);
    tmo_run(1'b0);
    repeat (20) @(negedge clk);
    tmo_run(1'b1);

    for (int r = 0; r < 20; r++) begin
      logic [15:0] j1, j2, j1a, j2a;
      bit chg;
      int n;
      j1  = 16'($urandom);
      j2  = 16'($urandom);
      j1a = 16'($urandom);
      j2a = 16'($urandom);
      chg = 1'($urandom_range(0, 1));
      n   = 30 + int'($urandom_range(0, 5));
      run_frame(j1, j2, chg, j1a, j2a, n, got, dones);
      chk($sformatf("rnd%0d_bits", r), got, model(j1, j2, n));
      chk($sformatf("rnd%0d_done", r), 64'(dones), 64'((n >= 32) ? 1 : 0));
    end

    chk("done_with_released_data", 64'(bad_done), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
